aes_sub_shift: RTL and testbench

Round-front stage of the AES datapath: applies SubBytes to a 128-bit state, then ShiftRows. It registers the result and pulses a completion flag. The output feeds the MixColumns stage directly: `out` drives its `in`, and `out_flag` drives its `col_mix_en`. `out` is held stable between results, so the downstream stage can sample it over several cycles.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_sbox.sv | 19 +
 rtl/aes_sub_shift.sv | 116 +++++++++++
 tb/tb_aes_sub_shift.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, S-box tables and the ShiftRows source-index helper.
// The inverse table exists only when AES_SUB_SHIFT_INV_EN is defined.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } aes_state_t;

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_SUB_SHIFT_INV_EN
  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  // Source byte index for output row r, column c; column arithmetic wraps mod 4.
  function automatic logic [3:0] shift_idx(input logic [1:0] r, input logic [1:0] c, input logic inv);
    logic [1:0] src_col;
    src_col = inv ? (c - r) : (c + r);
    return {src_col, r};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte S-box lookup, zero latency, no flow control.
// Inverse table is selectable only when AES_SUB_SHIFT_INV_EN is defined.
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte_t i_dat,
  input  logic      i_inv,
  output aes_byte_t o_dat
);

`ifdef AES_SUB_SHIFT_INV_EN
  assign o_dat = i_inv ? INV_SBOX[i_dat] : SBOX[i_dat];
`else
  logic w_unused_inv;
  assign w_unused_inv = i_inv;
  assign o_dat        = SBOX[i_dat];
`endif

endmodule

// File: rtl/aes_sub_shift.sv
// SubBytes (one column per cycle) then ShiftRows; 5 cycles strobe-to-flag, out held between results.
// sub_en is only sampled in IDLE and never queued. Inverse path under AES_SUB_SHIFT_INV_EN.
module aes_sub_shift
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in,
  input  logic         sub_en,
  input  logic         inv,
  output logic [127:0] out,
  output logic         out_flag,
  output logic         busy
);

  aes_state_t       r_state;
  aes_state_t       w_next;
  logic [1:0]       r_cnt;
  logic [0:15][7:0] r_in_q;
  logic [0:15][7:0] r_sub_q;
  logic [0:15][7:0] r_out;
  logic [0:15][7:0] w_shift;
  logic             r_out_flag;
  logic             w_inv;
  aes_byte_t        w_sub_col [4];

`ifdef AES_SUB_SHIFT_INV_EN
  logic r_inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv_q <= 1'b0;
    end else if (r_state == IDLE && sub_en) begin
      r_inv_q <= inv;
    end
  end

  assign w_inv = r_inv_q;
`else
  logic w_unused_inv;
  assign w_unused_inv = inv;
  assign w_inv        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sub_en) w_next = SUB;
      SUB:     if (r_cnt == 2'd3) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Byte r of the current column sits at index 4*cnt + r.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_dat (r_in_q[{r_cnt, 2'(g)}]),
      .i_inv (w_inv),
      .o_dat (w_sub_col[g])
    );
  end

  always_comb begin
    w_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shift[4*c+r] = r_sub_q[shift_idx(2'(r), 2'(c), w_inv)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      r_in_q     <= '0;
      r_sub_q    <= '0;
      r_out      <= '0;
      r_out_flag <= 1'b0;
    end else begin
      r_out_flag <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sub_en) begin
            r_in_q <= in;
            r_cnt  <= 2'd0;
          end
        end
        SUB: begin
          for (int r = 0; r < 4; r++) begin
            r_sub_q[{r_cnt, 2'(r)}] <= w_sub_col[r];
          end
          r_cnt <= r_cnt + 2'd1;
        end
        DONE: begin
          r_out      <= w_shift;
          r_out_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out      = r_out;
  assign out_flag = r_out_flag;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_aes_sub_shift.sv
// Self-checking bench for aes_sub_shift: fixed vectors, random vectors against a
// GF(2^8)-derived reference, back-to-back strobes and a mid-operation reset.
module tb_aes_sub_shift;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in;
  logic         sub_en;
  logic         inv;
  logic [127:0] out;
  logic         out_flag;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  bit [7:0]     sb  [256];
  bit [7:0]     isb [256];
  logic [127:0] last_exp;

  aes_sub_shift dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .sub_en   (sub_en),
    .inv      (inv),
    .out      (out),
    .out_flag (out_flag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    bit           iv;
    logic [127:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [7:0] p = 8'h00;
    bit       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic bit [7:0] rotl(input bit [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic init_tables();
    bit [7:0] g;
    bit [7:0] s;
    for (int x = 0; x < 256; x++) begin
      g = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) g = 8'(y);
        end
      end
      s = g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] x, input bit iv);
    bit [7:0]     s [16];
    bit [7:0]     o [16];
    bit           eff;
    int           src;
    logic [127:0] res;
`ifdef AES_SUB_SHIFT_INV_EN
    eff = iv;
`else
    eff = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      s[i] = x[127-8*i -: 8];
      s[i] = eff ? isb[s[i]] : sb[s[i]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = eff ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[4*c+r] = s[4*src+r];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(input string tag, input logic [127:0] din, input bit iv, input logic [127:0] exp);
    int cycles = 0;
    bit seen   = 1'b0;
    in     = din;
    inv    = iv;
    sub_en = 1'b1;
    @(posedge clk); #1;
    sub_en = 1'b0;
    in     = ~din;
    inv    = ~iv;
    chk({tag, " busy_after_start"}, {127'd0, busy}, 128'd1);
    while (!seen && cycles < 12) begin
      @(posedge clk); #1;
      cycles++;
      if (out_flag) seen = 1'b1;
      else if (cycles == 4) chk({tag, " busy_mid"}, {127'd0, busy}, 128'd1);
    end
    chk({tag, " latency"}, 128'(cycles), 128'd5);
    chk({tag, " out"}, out, exp);
    chk({tag, " busy_at_flag"}, {127'd0, busy}, 128'd0);
    @(posedge clk); #1;
    chk({tag, " flag_one_cycle"}, {127'd0, out_flag}, 128'd0);
    chk({tag, " out_held"}, out, exp);
    last_exp = exp;
  endtask

  initial begin
    vec_t         vecs [$];
    logic [127:0] ins  [18];
    bit           invs [18];
    logic [127:0] exp;
    int           flags;

    init_tables();
    rst_n  = 1'b0;
    in     = '0;
    sub_en = 1'b0;
    inv    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", out, 128'd0);
    chk("reset_flag", {127'd0, out_flag}, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("idle_out", out, 128'd0);
      chk("idle_flag", {127'd0, out_flag}, 128'd0);
      chk("idle_busy", {127'd0, busy}, 128'd0);
    end

    vecs.push_back('{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
    vecs.push_back('{128'd0, 1'b0, {16{8'h63}}});
`ifdef AES_SUB_SHIFT_INV_EN
    vecs.push_back('{{16{8'h63}}, 1'b1, 128'd0});
`else
    vecs.push_back('{{16{8'h63}}, 1'b1, {16{8'hfb}}});
`endif
    for (int k = 0; k < 12; k++) begin
      logic [127:0] d;
      bit           b;
      d = rnd128();
      b = 1'($urandom_range(0, 1));
      vecs.push_back('{d, b, model(d, b)});
    end

    for (int k = 0; k < vecs.size(); k++) begin
      run_op($sformatf("vec%0d", k), vecs[k].din, vecs[k].iv, vecs[k].exp);
    end

    // Strobe held high: only edges 0, 6 and 12 start operations.
    for (int k = 0; k < 18; k++) begin
      ins[k]  = rnd128();
      invs[k] = 1'($urandom_range(0, 1));
      in      = ins[k];
      inv     = invs[k];
      sub_en  = 1'b1;
      @(posedge clk); #1;
      if (k == 5 || k == 11 || k == 17) begin
        exp = model(ins[k-5], invs[k-5]);
        chk($sformatf("b2b_flag_e%0d", k), {127'd0, out_flag}, 128'd1);
        chk($sformatf("b2b_out_e%0d", k), out, exp);
        last_exp = exp;
      end else begin
        chk($sformatf("b2b_noflag_e%0d", k), {127'd0, out_flag}, 128'd0);
        chk($sformatf("b2b_stable_e%0d", k), out, last_exp);
      end
    end
    sub_en = 1'b0;
    @(posedge clk); #1;

    // Reset asserted after E3 of an operation.
    in     = rnd128();
    inv    = 1'b0;
    sub_en = 1'b1;
    @(posedge clk); #1;
    sub_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out", out, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_flag", {127'd0, out_flag}, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    flags = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_flag) flags++;
    end
    chk("abort_no_flag", 128'(flags), 128'd0);
    chk("abort_out_after", out, 128'd0);
    run_op("post_reset", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
           128'hd4bf5d30e0b452aeb84111f11e2798e5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
